id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_valid  input  1  ID holds a real instruction.
REQ-005 SHALL have port id_pc  input  XLEN  ID instruction PC.
REQ-006 SHALL have port id_rs1_data  input  XLEN  regfile read data, rs1.
REQ-007 SHALL have port id_rs2_data  input  XLEN  regfile read data, rs2.
REQ-008 SHALL have port id_imm  input  XLEN  decoded immediate.
REQ-009 SHALL have port id_rd  input  5  destination register.
REQ-010 SHALL have port id_ctrl  input  12  packed ctrl_t {alu_op[4:0], reg_write, mem_read, mem_write, mem_size[2:0], branch}.
REQ-011 SHALL have port id_forward_rs1  input  2  hazard-unit forward select, rs1 (00 none, 01 EX, 10 MA, 11 WB).
REQ-012 SHALL have port id_forward_rs2  input  2  hazard-unit forward select, rs2.
REQ-013 SHALL have port stall_pipeline  input  1  load-use stall from hazard detection.
REQ-014 SHALL have port flush_ex  input  1  kill request (taken branch/jump resolved in EX).
REQ-015 SHALL have port hold_ex  input  1  EX busy (multi-cycle MUL/DIV); freeze this register.
REQ-016 SHALL have ports ex_valid/ex_pc/ex_rs1_data/ex_rs2_data/ex_imm  output  1/XLEN/XLEN/XLEN/XLEN  registered copies.
REQ-017 SHALL have ports ex_rd/ex_ctrl  output  5/12  registered copies.
REQ-018 SHALL have ports ex_forward_rs1/ex_forward_rs2  output  2/2  registered forward selects, passed unchanged.
REQ-019 SHALL have port ex_is_load  output  1  ex_valid & ex_ctrl.mem_read (to hazard unit is_load_ex).
REQ-020 SHALL have port ex_reg_write_enable  output  1  ex_valid & ex_ctrl.reg_write & (ex_rd != 0).

Function
REQ-021 SHALL update at each rising clk edge with priority flush_ex > hold_ex > stall_pipeline > load; latency ID->EX exactly 1 cycle.
REQ-022 flush_ex=1 SHALL write bubble: ex_valid=0, ex_ctrl=0, ex_rd=0, ex_forward_*=00; data registers hold; flush overrides simultaneous hold_ex.
REQ-023 hold_ex=1 (no flush) SHALL keep every ex_* output unchanged, regardless of stall_pipeline or id_*.
REQ-024 stall_pipeline=1 (no flush, no hold) SHALL insert bubble as REQ-022; ID instruction is not consumed.
REQ-025 Load (none of the above) SHALL capture all id_* into ex_*; if id_valid=0, ex_ctrl, ex_rd, ex_forward_* SHALL be captured as zero.
REQ-026 ex_is_load and ex_reg_write_enable SHALL be combinational from registered state only, never from id_* or control inputs.
REQ-027 A bubble SHALL never assert ex_is_load or ex_reg_write_enable, so a stall cannot self-sustain beyond one cycle.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear all ex_* registers to zero; outputs zero while asserted; first capture on first rising edge after deassertion, even mid-stall/hold.

Configuration
REQ-029 With ID_EX_PERF_CNT_EN defined, SHALL add outputs bubble_count[31:0] (bubbles from REQ-024) and flush_count[31:0] (cycles flush_ex=1 and ex_valid=1), saturating at all-ones, cleared by reset; without it, ports and logic SHALL be absent and REQ-001..028 unchanged.

Structure
REQ-030 ctrl_t, FWD_NONE/FWD_EX/FWD_MA/FWD_WB constants and XLEN default SHALL live in shared package cpu_pipe_pkg.
REQ-031 Perf counters SHALL be one sub-module id_ex_perf_counter, instantiated only under ID_EX_PERF_CNT_EN.

Verification
REQ-032 Load id_valid=1, id_pc=0x100, id_rd=5, reg_write=1 -> next cycle ex_pc=0x100, ex_rd=5, ex_reg_write_enable=1.
REQ-033 Load with mem_read=1, rd=3, then stall_pipeline=1 one cycle -> ex_is_load=1 then bubble (ex_valid=0, ex_is_load=0); stalled instruction loads next cycle.
REQ-034 hold_ex=1 for 3 cycles with changing id_* -> ex_* constant; stall_pipeline=1 during hold inserts no bubble.
REQ-035 flush_ex=1 and hold_ex=1 together -> ex_valid=0, ex_ctrl=0; flush_count+1 when ID_EX_PERF_CNT_EN.
REQ-036 reset_n low asynchronously mid-hold -> all ex_* zero before next clk edge; counters zero.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: packed control word, forward-select codes and default datapath width.
package cpu_pipe_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MA   = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_perf_counter.sv
// Saturating bubble/flush event counters for the ID/EX register; present only when
// ID_EX_PERF_CNT_EN is defined.
module id_ex_perf_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_bubble,
    input  logic        i_flush,
    output logic [31:0] o_bubble_count,
    output logic [31:0] o_flush_count
);

    logic        w_inc [2];
    logic [31:0] w_cnt [2];

    assign w_inc[0] = i_bubble;
    assign w_inc[1] = i_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [31:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (w_inc[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign o_bubble_count = w_cnt[0];
    assign o_flush_count  = w_cnt[1];

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with flush > hold > stall > load priority.
// Define ID_EX_PERF_CNT_EN to add the bubble_count/flush_count outputs.
module id_ex_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd,
    input  logic [11:0]     id_ctrl,
    input  logic [1:0]      id_forward_rs1,
    input  logic [1:0]      id_forward_rs2,
    input  logic            stall_pipeline,
    input  logic            flush_ex,
    input  logic            hold_ex,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [11:0]     ex_ctrl,
    output logic [1:0]      ex_forward_rs1,
    output logic [1:0]      ex_forward_rs2,
    output logic            ex_is_load,
    output logic            ex_reg_write_enable
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     bubble_count,
    output logic [31:0]     flush_count
`endif
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd;
    ctrl_t           r_ctrl;
    logic [1:0]      r_fwd_rs1;
    logic [1:0]      r_fwd_rs2;

    logic w_bubble;
    logic w_load;

    // A stall only turns into a bubble when EX is free to accept one.
    assign w_bubble = flush_ex || (!hold_ex && stall_pipeline);
    assign w_load   = !flush_ex && !hold_ex && !stall_pipeline;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_ctrl     <= CTRL_NOP;
            r_fwd_rs1  <= FWD_NONE;
            r_fwd_rs2  <= FWD_NONE;
        end else if (w_bubble) begin
            // Data words are left as-is; only the qualifying fields are cleared.
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_ctrl    <= CTRL_NOP;
            r_fwd_rs1 <= FWD_NONE;
            r_fwd_rs2 <= FWD_NONE;
        end else if (w_load) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rd       <= id_valid ? id_rd : 5'd0;
            r_ctrl     <= id_valid ? ctrl_t'(id_ctrl) : CTRL_NOP;
            r_fwd_rs1  <= id_valid ? id_forward_rs1 : FWD_NONE;
            r_fwd_rs2  <= id_valid ? id_forward_rs2 : FWD_NONE;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_rs1_data    = r_rs1_data;
    assign ex_rs2_data    = r_rs2_data;
    assign ex_imm         = r_imm;
    assign ex_rd          = r_rd;
    assign ex_ctrl        = r_ctrl;
    assign ex_forward_rs1 = r_fwd_rs1;
    assign ex_forward_rs2 = r_fwd_rs2;

    assign ex_is_load          = r_valid && r_ctrl.mem_read;
    assign ex_reg_write_enable = r_valid && r_ctrl.reg_write && (r_rd != 5'd0);

`ifdef ID_EX_PERF_CNT_EN
    logic w_stall_bubble;
    logic w_flush_live;

    assign w_stall_bubble = !flush_ex && !hold_ex && stall_pipeline;
    assign w_flush_live   = flush_ex && r_valid;

    id_ex_perf_counter u_perf (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_bubble       (w_stall_bubble),
        .i_flush        (w_flush_live),
        .o_bubble_count (bubble_count),
        .o_flush_count  (flush_count)
    );
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed vector bench for id_ex_stage_reg; counter checks are active when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rd;
    logic [11:0] id_ctrl;
    logic [1:0]  id_forward_rs1, id_forward_rs2;
    logic        stall_pipeline, flush_ex, hold_ex;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [11:0] ex_ctrl;
    logic [1:0]  ex_forward_rs1, ex_forward_rs2;
    logic        ex_is_load, ex_reg_write_enable;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_count, flush_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .id_valid            (id_valid),
        .id_pc               (id_pc),
        .id_rs1_data         (id_rs1_data),
        .id_rs2_data         (id_rs2_data),
        .id_imm              (id_imm),
        .id_rd               (id_rd),
        .id_ctrl             (id_ctrl),
        .id_forward_rs1      (id_forward_rs1),
        .id_forward_rs2      (id_forward_rs2),
        .stall_pipeline      (stall_pipeline),
        .flush_ex            (flush_ex),
        .hold_ex             (hold_ex),
        .ex_valid            (ex_valid),
        .ex_pc               (ex_pc),
        .ex_rs1_data         (ex_rs1_data),
        .ex_rs2_data         (ex_rs2_data),
        .ex_imm              (ex_imm),
        .ex_rd               (ex_rd),
        .ex_ctrl             (ex_ctrl),
        .ex_forward_rs1      (ex_forward_rs1),
        .ex_forward_rs2      (ex_forward_rs2),
        .ex_is_load          (ex_is_load),
        .ex_reg_write_enable (ex_reg_write_enable)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_count        (bubble_count),
        .flush_count         (flush_count)
`endif
    );

    typedef struct {
        logic         flush, hold, stall, valid;
        logic [31:0]  pc, rs1, rs2, imm;
        logic [4:0]   rd;
        logic [11:0]  ctrl;
        logic [1:0]   f1, f2;
        logic [151:0] exp;
        logic [31:0]  exp_bub, exp_fl;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    function automatic logic [151:0] e(input logic v, input logic [31:0] pc, rs1, rs2, imm,
                                       input logic [4:0] rd, input logic [11:0] ctrl,
                                       input logic [1:0] f1, f2, input logic ld, rwe);
        return {v, pc, rs1, rs2, imm, rd, ctrl, f1, f2, ld, rwe};
    endfunction

    function automatic vec_t mk(input logic fl, ho, st, va, input logic [31:0] pc, rs1, rs2, imm,
                                input logic [4:0] rd, input logic [11:0] ctrl, input logic [1:0] f1, f2,
                                input logic [151:0] ex, input logic [31:0] eb, ef);
        vec_t r;
        r.flush = fl; r.hold = ho; r.stall = st; r.valid = va;
        r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        r.rd = rd; r.ctrl = ctrl; r.f1 = f1; r.f2 = f2;
        r.exp = ex; r.exp_bub = eb; r.exp_fl = ef;
        return r;
    endfunction

    function automatic logic [151:0] actual();
        return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_ctrl,
                ex_forward_rs1, ex_forward_rs2, ex_is_load, ex_reg_write_enable};
    endfunction

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] eb, input logic [31:0] ef);
`ifdef ID_EX_PERF_CNT_EN
        n_tests++;
        if ({bubble_count, flush_count} !== {eb, ef}) begin
            n_fail++;
            $display("FAIL %s: got bubble=%0d flush=%0d required bubble=%0d flush=%0d",
                     name, bubble_count, flush_count, eb, ef);
        end else begin
            $display("ok   %s: bubble=%0d flush=%0d", name, bubble_count, flush_count);
        end
`else
        if (name.len() < 0) $display("%0d %0d", eb, ef);
`endif
    endtask

    task automatic drive(input vec_t t);
        flush_ex = t.flush; hold_ex = t.hold; stall_pipeline = t.stall; id_valid = t.valid;
        id_pc = t.pc; id_rs1_data = t.rs1; id_rs2_data = t.rs2; id_imm = t.imm;
        id_rd = t.rd; id_ctrl = t.ctrl; id_forward_rs1 = t.f1; id_forward_rs2 = t.f2;
    endtask

    initial begin
        vec_t h;
        // ctrl encodings: 0C0 = alu_op 1 + reg_write, 060 = reg_write + mem_read (load)
        tbl[0]  = mk(0,0,0,1, 32'h100,32'h11,32'h22,32'h33, 5'd5, 12'h0C0, 2'd1,2'd2,
                     e(1,32'h100,32'h11,32'h22,32'h33,5'd5,12'h0C0,2'd1,2'd2,0,1), 0, 0);
        tbl[1]  = mk(0,0,0,1, 32'h104,32'hA1,32'hA2,32'hA3, 5'd3, 12'h060, 2'd0,2'd0,
                     e(1,32'h104,32'hA1,32'hA2,32'hA3,5'd3,12'h060,2'd0,2'd0,1,1), 0, 0);
        tbl[2]  = mk(0,0,1,1, 32'h108,32'hB1,32'hB2,32'hB3, 5'd7, 12'h0C0, 2'd3,2'd1,
                     e(0,32'h104,32'hA1,32'hA2,32'hA3,5'd0,12'h000,2'd0,2'd0,0,0), 1, 0);
        tbl[3]  = mk(0,0,0,1, 32'h108,32'hB1,32'hB2,32'hB3, 5'd7, 12'h0C0, 2'd3,2'd1,
                     e(1,32'h108,32'hB1,32'hB2,32'hB3,5'd7,12'h0C0,2'd3,2'd1,0,1), 1, 0);
        tbl[4]  = mk(0,1,0,1, 32'h200,32'hC1,32'hC2,32'hC3, 5'd9, 12'h060, 2'd2,2'd2,
                     e(1,32'h108,32'hB1,32'hB2,32'hB3,5'd7,12'h0C0,2'd3,2'd1,0,1), 1, 0);
        tbl[5]  = mk(0,1,1,1, 32'h204,32'hC4,32'hC5,32'hC6, 5'd10, 12'h060, 2'd1,2'd1,
                     e(1,32'h108,32'hB1,32'hB2,32'hB3,5'd7,12'h0C0,2'd3,2'd1,0,1), 1, 0);
        tbl[6]  = mk(0,1,0,0, 32'h208,32'hC7,32'hC8,32'hC9, 5'd11, 12'hFFF, 2'd3,2'd3,
                     e(1,32'h108,32'hB1,32'hB2,32'hB3,5'd7,12'h0C0,2'd3,2'd1,0,1), 1, 0);
        tbl[7]  = mk(1,1,0,1, 32'h20C,32'hD1,32'hD2,32'hD3, 5'd12, 12'h060, 2'd1,2'd1,
                     e(0,32'h108,32'hB1,32'hB2,32'hB3,5'd0,12'h000,2'd0,2'd0,0,0), 1, 1);
        tbl[8]  = mk(0,0,0,0, 32'h300,32'hE1,32'hE2,32'hE3, 5'd12, 12'h0C0, 2'd2,2'd2,
                     e(0,32'h300,32'hE1,32'hE2,32'hE3,5'd0,12'h000,2'd0,2'd0,0,0), 1, 1);
        tbl[9]  = mk(0,0,0,1, 32'h304,32'hF1,32'hF2,32'hF3, 5'd0, 12'h0C0, 2'd1,2'd1,
                     e(1,32'h304,32'hF1,32'hF2,32'hF3,5'd0,12'h0C0,2'd1,2'd1,0,0), 1, 1);
        tbl[10] = mk(0,0,0,1, 32'h308,32'h71,32'h72,32'h73, 5'd31, 12'hFFF, 2'd3,2'd3,
                     e(1,32'h308,32'h71,32'h72,32'h73,5'd31,12'hFFF,2'd3,2'd3,1,1), 1, 1);
        tbl[11] = mk(1,0,0,1, 32'h30C,32'h81,32'h82,32'h83, 5'd4, 12'h0C0, 2'd1,2'd1,
                     e(0,32'h308,32'h71,32'h72,32'h73,5'd0,12'h000,2'd0,2'd0,0,0), 1, 2);
        tbl[12] = mk(1,0,1,1, 32'h400,32'h91,32'h92,32'h93, 5'd1, 12'h060, 2'd0,2'd2,
                     e(0,32'h308,32'h71,32'h72,32'h73,5'd0,12'h000,2'd0,2'd0,0,0), 1, 2);
        tbl[13] = mk(0,0,0,1, 32'h400,32'h91,32'h92,32'h93, 5'd1, 12'h060, 2'd0,2'd2,
                     e(1,32'h400,32'h91,32'h92,32'h93,5'd1,12'h060,2'd0,2'd2,1,1), 1, 2);

        reset_n = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0, 0, 0, 0,0, '0, 0, 0));
        #2;
        check("reset_state", actual(), '0);
        check_cnt("reset_counters", 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), actual(), tbl[i].exp);
            check_cnt($sformatf("vec%0d_cnt", i), tbl[i].exp_bub, tbl[i].exp_fl);
        end

        // Status outputs must ignore input changes between edges.
        @(negedge clk);
        id_valid = 1'b0; flush_ex = 1'b1; stall_pipeline = 1'b1; id_ctrl = 12'h000;
        #1;
        check("status_from_regs", {150'd0, ex_is_load, ex_reg_write_enable}, {150'd0, 2'b11});
        @(posedge clk);
        #1;
        check("flush_after_load", actual(),
              e(0,32'h400,32'h91,32'h92,32'h93,5'd0,12'h000,2'd0,2'd0,0,0));
        check_cnt("flush_after_load_cnt", 1, 3);

        // Async reset asserted mid-cycle while EX is holding.
        @(negedge clk);
        h = mk(0,1,1,1, 32'h500,32'h55,32'h56,32'h57, 5'd2, 12'h0C0, 2'd1,2'd1, '0, 0, 0);
        drive(h);
        @(posedge clk);
        #1;
        check("hold_on_bubble", actual(),
              e(0,32'h400,32'h91,32'h92,32'h93,5'd0,12'h000,2'd0,2'd0,0,0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_hold", actual(), '0);
        check_cnt("async_reset_counters", 0, 0);

        @(negedge clk);
        reset_n = 1'b1;
        h = mk(0,0,0,1, 32'h600,32'h61,32'h62,32'h63, 5'd6, 12'h0C0, 2'd2,2'd0, '0, 0, 0);
        drive(h);
        @(posedge clk);
        #1;
        check("first_load_after_reset", actual(),
              e(1,32'h600,32'h61,32'h62,32'h63,5'd6,12'h0C0,2'd2,2'd0,0,1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
